// File: rtl/mem_port_arbiter.sv
// Multi-port memory request arbiter: picks one requester per cycle, forwards its
// message to memory, and steers in-order memory responses back via a tag FIFO.
module mem_port_arbiter #(
    parameter int NPORTS   = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0,
    localparam int REQ_SZ  = 1 + AW + 2 + DW,
    localparam int RESP_SZ = 1 + 2 + DW,
    localparam int TW      = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS*REQ_SZ-1:0]  req_msg,
    input  logic [NPORTS-1:0]         req_val,
    output logic [NPORTS-1:0]         req_rdy,
    output logic [NPORTS*RESP_SZ-1:0] resp_msg,
    output logic [NPORTS-1:0]         resp_val,
    output logic [REQ_SZ-1:0]         memreq_msg,
    output logic                      memreq_val,
    input  logic                      memreq_rdy,
    input  logic [RESP_SZ-1:0]        memresp_msg,
    input  logic                      memresp_val,
    output logic [CW-1:0]             outstanding,
    output logic                      err_orphan
);

    localparam int PW = $clog2(DEPTH);

    logic [TW-1:0]     ptr_reg, ptr_next;
    logic [TW-1:0]     tag_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic              err_orphan_reg;

    logic [NPORTS-1:0] hi_mask, req_hi, pick_vec, grant_vec;
    logic [TW-1:0]     idx_acc [NPORTS+1];
    logic [REQ_SZ-1:0] msg_acc [NPORTS+1];
    logic [TW-1:0]     grant_idx, head_tag;
    logic              full, fire, pop, orphan_hit;

    // Round-robin: prefer requesters at or above ptr, otherwise wrap to the lowest.
    // Fixed priority simply leaves the upper mask empty.
    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_mask
            assign hi_mask[gi] = (ARB_MODE == 0) && (TW'(gi) >= ptr_reg);
        end
    endgenerate

    assign req_hi    = req_val & hi_mask;
    assign pick_vec  = (|req_hi) ? req_hi : req_val;
    assign grant_vec = pick_vec & (~pick_vec + NPORTS'(1));

    assign idx_acc[0] = '0;
    assign msg_acc[0] = '0;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_encode
            assign idx_acc[gi+1] = idx_acc[gi] | (grant_vec[gi] ? TW'(gi) : '0);
            assign msg_acc[gi+1] = msg_acc[gi]
                                 | ({REQ_SZ{grant_vec[gi]}} & req_msg[gi*REQ_SZ +: REQ_SZ]);
        end
    endgenerate

    assign grant_idx  = idx_acc[NPORTS];
    assign memreq_msg = msg_acc[NPORTS];

    assign full       = (count_reg == CW'(DEPTH));
    assign memreq_val = reset && (|req_val) && !full;
    assign fire       = memreq_val && memreq_rdy;
    assign pop        = reset && memresp_val && (count_reg != '0);
    assign orphan_hit = memresp_val && (count_reg == '0);
    assign head_tag   = tag_mem[rd_ptr_reg];

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_ports
            assign req_rdy[gi]                       = fire && grant_vec[gi];
            assign resp_val[gi]                      = pop && (head_tag == TW'(gi));
            assign resp_msg[gi*RESP_SZ +: RESP_SZ]   = memresp_msg;
        end
    endgenerate

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (fire) begin
            ptr_next = (grant_idx == TW'(NPORTS - 1)) ? '0 : grant_idx + TW'(1);
        end
        // Fire is blocked when full and pop needs an entry, so this never wraps.
        if (fire && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !fire) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            err_orphan_reg <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            if (fire) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (orphan_hit) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

    assign outstanding = count_reg;
    assign err_orphan  = err_orphan_reg;

endmodule
